// File: rtl/lfsr_keystream_if.sv
// Bus between the register-file write port / read mux and the LFSR keystream block.
// master: register file side (drives the write bus and step strobe).
// slave : keystream block (returns state, taps and burst status).
interface lfsr_keystream_if #(
    parameter int W = 8,
    parameter int S = 7
);
    logic         reg_write;
    logic [1:0]   reg_dest;
    logic [W-1:0] data_in;
    logic         next_lfsr;
    logic [W-1:0] state_out;
    logic [S-1:0] taps_out;
    logic         busy;

    modport master (
        output reg_write, reg_dest, data_in, next_lfsr,
        input  state_out, taps_out, busy
    );

    modport slave (
        input  reg_write, reg_dest, data_in, next_lfsr,
        output state_out, taps_out, busy
    );
endinterface

// File: rtl/lfsr_keystream.sv
// LFSR keystream generator feeding the register file's second read port.
// Taps and state are loaded from the register-file write bus; the LFSR advances
// one step per next_lfsr pulse while idle, or autonomously for N steps in a burst.
// Optional build macro: LFSR_PARITY_EN puts even parity of the state in the top
// bit of state_out; without it the state is zero-extended.
module lfsr_keystream #(
    parameter int W = 8,
    parameter int S = 7
) (
    input  logic               clk_i,
    input  logic               rst_i,
    lfsr_keystream_if.slave    bus
);

    localparam int CW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    localparam logic [1:0] DEST_TAPS  = 2'b01;
    localparam logic [1:0] DEST_SEED  = 2'b10;
    localparam logic [1:0] DEST_BURST = 2'b11;

    fsm_t          fsm_q,   fsm_d;
    logic [S-1:0]  state_q, state_d;
    logic [S-1:0]  taps_q,  taps_d;
    logic [CW-1:0] count_q, count_d;

    logic          wr_taps;
    logic          wr_seed;
    logic          wr_burst;
    logic          fb;
    logic [S-1:0]  state_step;

    // Upper data bits beyond the state width are not consumed by this block.
    logic          unused_data_hi;
    assign unused_data_hi = ^bus.data_in[W-1:S];

    assign wr_taps  = bus.reg_write && (bus.reg_dest == DEST_TAPS);
    assign wr_seed  = bus.reg_write && (bus.reg_dest == DEST_SEED);
    assign wr_burst = bus.reg_write && (bus.reg_dest == DEST_BURST);

    // Fibonacci feedback; a zero state or zero taps yields fb=0, so all-zero is a fixed point.
    assign fb         = ^(state_q & taps_q);
    assign state_step = {state_q[S-2:0], fb};

    // State register: FSM, LFSR state, taps and burst counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            taps_q  <= '0;
            count_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            taps_q  <= taps_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: write > burst step > single step; taps/seed writes abort a burst.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        taps_d  = taps_q;
        count_d = count_q;
        if (wr_taps) begin
            taps_d  = bus.data_in[S-1:0];
            fsm_d   = IDLE;
            count_d = '0;
        end else if (wr_seed) begin
            state_d = bus.data_in[S-1:0];
            fsm_d   = IDLE;
            count_d = '0;
        end else if (wr_burst) begin
            count_d = bus.data_in[CW-1:0];
            fsm_d   = (bus.data_in[CW-1:0] != '0) ? RUN : IDLE;
        end else if (fsm_q == RUN) begin
            // next_lfsr is deliberately ignored here: the burst owns the step.
            state_d = state_step;
            count_d = count_q - 1'b1;
            if (count_q == {{(CW-1){1'b0}}, 1'b1}) begin
                fsm_d = IDLE;
            end
        end else if (bus.next_lfsr) begin
            state_d = state_step;
        end
    end

    // Output decode: all outputs come straight from registers through the pad/parity mux.
    always_comb begin
        bus.state_out          = '0;
        bus.state_out[S-1:0]   = state_q;
`ifdef LFSR_PARITY_EN
        bus.state_out[W-1]     = ^state_q;
`endif
        bus.taps_out           = taps_q;
        bus.busy               = (fsm_q == RUN);
    end

endmodule

// File: tb/tb_lfsr_keystream.sv
// Self-checking bench for lfsr_keystream: directed scenarios plus randomized
// write/step traffic, compared against a behavioural model of the keystream rules.
module tb_lfsr_keystream;

    localparam int W = 8;
    localparam int S = 7;
    localparam int SMASK = (1 << S) - 1;

    logic clk;
    logic rst;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    int  m_state;
    int  m_taps;
    int  m_count;
    bit  m_run;

    lfsr_keystream_if #(.W(W), .S(S)) bus ();

    lfsr_keystream #(.W(W), .S(S)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int lfsr_next(input int s, input int t);
        int fb;
        fb = $countones(s & t) % 2;
        return ((s << 1) | fb) & SMASK;
    endfunction

    function automatic int expected_out(input int s);
        int v;
        v = s;
`ifdef LFSR_PARITY_EN
        v = v | (($countones(s) % 2) << (W - 1));
`endif
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_taps  = 0;
        m_count = 0;
        m_run   = 1'b0;
    endtask

    // One clock edge of the keystream rules, in priority order.
    task automatic model_clock(input bit we, input bit [1:0] dest, input int data, input bit nxt);
        if (we && dest == 2'b01) begin
            m_taps  = data & SMASK;
            m_run   = 1'b0;
            m_count = 0;
        end else if (we && dest == 2'b10) begin
            m_state = data & SMASK;
            m_run   = 1'b0;
            m_count = 0;
        end else if (we && dest == 2'b11) begin
            m_count = data & 15;
            m_run   = (m_count != 0);
        end else if (m_run) begin
            m_state = lfsr_next(m_state, m_taps);
            m_count = m_count - 1;
            m_run   = (m_count != 0);
        end else if (nxt) begin
            m_state = lfsr_next(m_state, m_taps);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".state"}, 32'(bus.state_out), 32'(expected_out(m_state)));
        check({tag, ".taps"},  32'(bus.taps_out),  32'(m_taps));
        check({tag, ".busy"},  32'(bus.busy),      32'(m_run));
    endtask

    // Apply inputs for one cycle, advance the model on the edge, then compare.
    task automatic drive_cycle(input bit we, input bit [1:0] dest, input int data,
                               input bit nxt, input string tag);
        bus.reg_write = we;
        bus.reg_dest  = dest;
        bus.data_in   = W'(data);
        bus.next_lfsr = nxt;
        @(posedge clk);
        model_clock(we, dest, data, nxt);
        #1;
        bus.reg_write = 1'b0;
        bus.reg_dest  = 2'b00;
        bus.next_lfsr = 1'b0;
        check_outputs(tag);
        $display("[TB] %s we=%0d dest=%0d data=0x%0h nxt=%0d -> state_out=0x%0h busy=%0d",
                 tag, we, dest, data, nxt, bus.state_out, bus.busy);
    endtask

    int exp_seq [6] = '{32'h02, 32'h04, 32'h08, 32'h10, 32'h20, 32'h41};
    int busy_cycles;

    initial begin
        rst           = 1'b1;
        bus.reg_write = 1'b0;
        bus.reg_dest  = 2'b00;
        bus.data_in   = '0;
        bus.next_lfsr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // Reset in the middle of a burst with three steps remaining.
        drive_cycle(1'b1, 2'b01, 32'h60, 1'b0, "t1_taps");
        drive_cycle(1'b1, 2'b10, 32'h01, 1'b0, "t1_seed");
        drive_cycle(1'b1, 2'b11, 32'h05, 1'b0, "t1_burst");
        drive_cycle(1'b0, 2'b00, 0, 1'b0, "t1_run");
        drive_cycle(1'b0, 2'b00, 0, 1'b0, "t1_run");
        check("t1_busy_before_reset", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #2;
        model_reset();
        check_outputs("t1_async_reset");
        rst = 1'b0;
        drive_cycle(1'b0, 2'b00, 0, 1'b1, "t1_step_after_reset");
        check("t1_zero_after_step", 32'(bus.state_out), 32'd0);

        // Five single steps then a sixth that exercises the feedback.
        drive_cycle(1'b1, 2'b01, 32'h60, 1'b0, "t2_taps");
        drive_cycle(1'b1, 2'b10, 32'h01, 1'b0, "t2_seed");
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 2'b00, 0, 1'b1, "t2_step");
            if (i == 4) begin
`ifdef LFSR_PARITY_EN
                check("t6_parity_0x20", 32'(bus.state_out), 32'hA0);
`else
                check("t6_pad_0x20", 32'(bus.state_out), 32'h20);
`endif
            end else begin
                check("t2_seq", 32'(bus.state_out), 32'(exp_seq[i]));
            end
        end
        check("t6_out_0x41", 32'(bus.state_out), 32'h41);

        // Burst of 6 with next_lfsr held high throughout.
        drive_cycle(1'b1, 2'b10, 32'h01, 1'b0, "t3_seed");
        drive_cycle(1'b1, 2'b11, 32'h06, 1'b1, "t3_burst");
        busy_cycles = 0;
        for (int i = 0; i < 10 && bus.busy; i++) begin
            busy_cycles++;
            drive_cycle(1'b0, 2'b00, 0, 1'b1, "t3_run");
        end
        check("t3_busy_cycles", 32'(busy_cycles), 32'd6);
        check("t3_final_state", 32'(bus.state_out), 32'h41);

        // Zero-length burst, then seed load colliding with a step request.
        drive_cycle(1'b1, 2'b11, 32'h00, 1'b0, "t4_burst0");
        check("t4_busy", 32'(bus.busy), 32'd0);
        check("t4_state_kept", 32'(bus.state_out), 32'h41);
        drive_cycle(1'b1, 2'b10, 32'h35, 1'b1, "t4_seed_nxt");
        check("t4_seed_wins", 32'(bus.state_out[S-1:0]), 32'h35);

        // Lock-up: zero state with full taps never escapes.
        drive_cycle(1'b1, 2'b01, 32'h7F, 1'b0, "t5_taps");
        drive_cycle(1'b1, 2'b10, 32'h00, 1'b0, "t5_seed");
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 2'b00, 0, 1'b1, "t5_step");
            check("t5_lockup", 32'(bus.state_out), 32'h00);
        end

        // Abort a burst with a taps write, then reload a burst mid-run.
        drive_cycle(1'b1, 2'b10, 32'h11, 1'b0, "t7_seed");
        drive_cycle(1'b1, 2'b11, 32'h09, 1'b0, "t7_burst");
        drive_cycle(1'b0, 2'b00, 0, 1'b0, "t7_run");
        drive_cycle(1'b1, 2'b01, 32'h41, 1'b0, "t7_abort");
        check("t7_abort_idle", 32'(bus.busy), 32'd0);
        drive_cycle(1'b1, 2'b11, 32'h08, 1'b0, "t7_burst2");
        drive_cycle(1'b0, 2'b00, 0, 1'b0, "t7_run2");
        drive_cycle(1'b1, 2'b11, 32'h02, 1'b0, "t7_reload");
        drive_cycle(1'b0, 2'b00, 0, 1'b0, "t7_run3");
        drive_cycle(1'b0, 2'b00, 0, 1'b0, "t7_run3");
        check("t7_reload_done", 32'(bus.busy), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit       we;
            bit [1:0] dest;
            int       data;
            bit       nxt;
            we   = ($urandom_range(0, 99) < 25);
            dest = 2'($urandom_range(0, 3));
            data = int'($urandom_range(0, 255));
            if (dest == 2'b11) data = int'($urandom_range(0, 7));
            nxt  = 1'($urandom_range(0, 1));
            drive_cycle(we, dest, data, nxt, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
